// File: rtl/bsg_lfsr_checker_if.sv
// rtl/bsg_lfsr_checker_if.sv - received PRBS word stream (valid + data, no backpressure)
interface bsg_lfsr_checker_if #(
    parameter int width_p = 16
) ();
    logic               v;
    logic [width_p-1:0] data;

    modport master (output v, output data);
    modport slave  (input  v, input  data);
endinterface

// File: rtl/bsg_lfsr_checker.sv
// rtl/bsg_lfsr_checker.sv - self-synchronising Galois LFSR stream checker with lock and error count
module bsg_lfsr_checker #(
    parameter int                 width_p         = 16,
    parameter logic [width_p-1:0] xor_mask_p      = 16'hB400,
    parameter int                 sync_count_p    = 4,
    parameter int                 loss_thresh_p   = 3,
    parameter int                 err_cnt_width_p = 16
) (
    input  logic                       clk,
    input  logic                       reset_n_i,
    bsg_lfsr_checker_if.slave          rx,
    input  logic                       clear_i,
    input  logic                       resync_i,
    output logic                       locked_o,
    output logic                       err_o,
    output logic [err_cnt_width_p-1:0] err_count_o,
    output logic [width_p-1:0]         expected_o
);
    localparam int mw = $clog2(sync_count_p + 1);
    localparam int lw = $clog2(loss_thresh_p + 1);

    typedef enum logic [1:0] {hunt_s, verify_s, locked_s} state_t;

    state_t        state;
    logic [mw-1:0] match_cnt;
    logic [lw-1:0] miss_cnt;

    logic          mismatch;
    logic          data_zero;
    logic          err_hit;
    logic [mw-1:0] match_inc;
    logic [lw-1:0] miss_inc;

    function automatic logic [width_p-1:0] step(input logic [width_p-1:0] x);
        return {1'b0, x[width_p-1:1]} ^ (x[0] ? xor_mask_p : '0);
    endfunction

    always_comb begin
        mismatch  = (rx.data != expected_o);
        data_zero = (rx.data == '0);
        err_hit   = rx.v && (state == locked_s) && mismatch;
        match_inc = match_cnt + mw'(1);
        miss_inc  = miss_cnt + lw'(1);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= hunt_s;
            expected_o  <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            err_count_o <= '0;
        end else begin
            err_o <= err_hit;

            // clear wins over the old value, but an error on the same beat still counts
            if (clear_i)
                err_count_o <= err_hit ? err_cnt_width_p'(1) : '0;
            else if (err_hit && !(&err_count_o))
                err_count_o <= err_count_o + err_cnt_width_p'(1);

            if (resync_i) begin
                state     <= hunt_s;
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked_o  <= 1'b0;
            end else if (rx.v) begin
                case (state)
                    hunt_s: begin
                        if (!data_zero) begin
                            expected_o <= step(rx.data);
                            match_cnt  <= mw'(1);
                            state      <= verify_s;
                        end
                    end
                    verify_s: begin
                        if (!mismatch) begin
                            expected_o <= step(expected_o);
                            if (match_inc == mw'(sync_count_p)) begin
                                state     <= locked_s;
                                locked_o  <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else if (!data_zero) begin
                            expected_o <= step(rx.data);
                            match_cnt  <= mw'(1);
                        end else begin
                            state     <= hunt_s;
                            match_cnt <= '0;
                        end
                    end
                    locked_s: begin
                        // flywheel: the prediction never reseeds from data while locked
                        expected_o <= step(expected_o);
                        if (!mismatch) begin
                            miss_cnt <= '0;
                        end else if (miss_inc == lw'(loss_thresh_p)) begin
                            state    <= hunt_s;
                            locked_o <= 1'b0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_inc;
                        end
                    end
                    default: begin
                        state    <= hunt_s;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bsg_lfsr_checker.sv
// tb/tb_bsg_lfsr_checker.sv - scoreboard bench for bsg_lfsr_checker with directed PRBS vectors
module tb_bsg_lfsr_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear_a, resync_a, locked_a, err_a;
    logic [15:0] cnt_a, exp_a;
    logic        clear_b, resync_b, locked_b, err_b;
    logic [3:0]  cnt_b;
    logic [15:0] exp_b;

    bsg_lfsr_checker_if #(.width_p(16)) a_if ();
    bsg_lfsr_checker_if #(.width_p(16)) b_if ();

    bsg_lfsr_checker dut_a (
        .clk(clk), .reset_n_i(rst_n), .rx(a_if.slave),
        .clear_i(clear_a), .resync_i(resync_a),
        .locked_o(locked_a), .err_o(err_a), .err_count_o(cnt_a), .expected_o(exp_a)
    );

    bsg_lfsr_checker #(
        .width_p(16), .xor_mask_p(16'hB400), .sync_count_p(4),
        .loss_thresh_p(31), .err_cnt_width_p(4)
    ) dut_b (
        .clk(clk), .reset_n_i(rst_n), .rx(b_if.slave),
        .clear_i(clear_b), .resync_i(resync_b),
        .locked_o(locked_b), .err_o(err_b), .err_count_o(cnt_b), .expected_o(exp_b)
    );

    typedef struct {
        bit          inst;
        logic        l;
        logic        e;
        logic [15:0] c;
        logic [15:0] x;
        bit          cx;
        int          id;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   beat_id = 0;

    task automatic cmp(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s (beat %0d): got %h required %h", name, id, got, want);
        end
    endtask

    task automatic beat(input bit inst, input logic [15:0] d, input bit clr, input bit rs,
                        input logic l, input logic e, input logic [15:0] c,
                        input logic [15:0] x, input bit cx);
        exp_t it;
        if (inst == 1'b0) begin
            a_if.v = 1'b1; a_if.data = d; clear_a = clr; resync_a = rs;
        end else begin
            b_if.v = 1'b1; b_if.data = d; clear_b = clr; resync_b = rs;
        end
        it.inst = inst; it.l = l; it.e = e; it.c = c; it.x = x; it.cx = cx; it.id = beat_id;
        beat_id++;
        sbq.push_back(it);
        @(negedge clk);
        a_if.v = 1'b0; b_if.v = 1'b0;
        clear_a = 1'b0; resync_a = 1'b0; clear_b = 1'b0; resync_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitor: every accepted beat is checked one cycle later against the queued expectation
    initial begin
        bit   fa, fb;
        exp_t it;
        forever begin
            @(posedge clk);
            fa = a_if.v && rst_n;
            fb = b_if.v && rst_n;
            #1;
            if (fa || fb) begin
                if (sbq.size() == 0) begin
                    cmp("sb_underflow", beat_id, 32'd1, 32'd0);
                end else begin
                    it = sbq.pop_front();
                    if (it.inst == 1'b0) begin
                        cmp("locked", it.id, {31'd0, locked_a}, {31'd0, it.l});
                        cmp("err", it.id, {31'd0, err_a}, {31'd0, it.e});
                        cmp("err_count", it.id, {16'd0, cnt_a}, {16'd0, it.c});
                        if (it.cx) cmp("expected", it.id, {16'd0, exp_a}, {16'd0, it.x});
                    end else begin
                        cmp("b_locked", it.id, {31'd0, locked_b}, {31'd0, it.l});
                        cmp("b_err", it.id, {31'd0, err_b}, {31'd0, it.e});
                        cmp("b_err_count", it.id, {28'd0, cnt_b}, {16'd0, it.c});
                        if (it.cx) cmp("b_expected", it.id, {16'd0, exp_b}, {16'd0, it.x});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_if.v = 1'b0; a_if.data = '0; b_if.v = 1'b0; b_if.data = '0;
        clear_a = 1'b0; resync_a = 1'b0; clear_b = 1'b0; resync_b = 1'b0;
        idle(2);
        cmp("rst_locked", -1, {31'd0, locked_a}, 32'd0);
        cmp("rst_err", -1, {31'd0, err_a}, 32'd0);
        cmp("rst_count", -1, {16'd0, cnt_a}, 32'd0);
        cmp("rst_expected", -1, {16'd0, exp_a}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // lock acquisition
        beat(0, 16'h0001, 0, 0, 0, 0, 0, 16'hB400, 1);
        beat(0, 16'hB400, 0, 0, 0, 0, 0, 16'h5A00, 1);
        beat(0, 16'h5A00, 0, 0, 0, 0, 0, 16'h2D00, 1);
        beat(0, 16'h2D00, 0, 0, 1, 0, 0, 16'h1680, 1);
        // single error
        beat(0, 16'h1680, 0, 0, 1, 0, 0, 16'h0B40, 1);
        beat(0, 16'h1681, 0, 0, 1, 1, 1, 16'h05A0, 1);
        beat(0, 16'h05A0, 0, 0, 1, 0, 1, 16'h02D0, 1);
        // loss of lock after three misses, zero word counts as a miss
        beat(0, 16'hFFFF, 0, 0, 1, 1, 2, 16'h0168, 1);
        beat(0, 16'hFFFF, 0, 0, 1, 1, 3, 16'h00B4, 1);
        beat(0, 16'h0000, 0, 0, 0, 1, 4, 16'h005A, 1);
        // relock
        beat(0, 16'h0001, 0, 0, 0, 0, 4, 16'hB400, 1);
        beat(0, 16'hB400, 0, 0, 0, 0, 4, 16'h5A00, 1);
        beat(0, 16'h5A00, 0, 0, 0, 0, 4, 16'h2D00, 1);
        beat(0, 16'h2D00, 0, 0, 1, 0, 4, 16'h1680, 1);

        // standalone resync then clear
        resync_a = 1'b1;
        idle(1);
        resync_a = 1'b0;
        cmp("resync_locked", -1, {31'd0, locked_a}, 32'd0);
        cmp("resync_count", -1, {16'd0, cnt_a}, 32'd4);
        clear_a = 1'b1;
        idle(1);
        clear_a = 1'b0;
        cmp("clear_count", -1, {16'd0, cnt_a}, 32'd0);

        // HUNT ignores zero words, VERIFY reseeds, gaps do not advance
        beat(0, 16'h0000, 0, 0, 0, 0, 0, 16'h1680, 1);
        beat(0, 16'h0000, 0, 0, 0, 0, 0, 16'h1680, 1);
        beat(0, 16'h0001, 0, 0, 0, 0, 0, 16'hB400, 1);
        beat(0, 16'h1234, 0, 0, 0, 0, 0, 16'h091A, 1);
        idle(5);
        cmp("gap_expected", -1, {16'd0, exp_a}, 32'h091A);
        beat(0, 16'h091A, 0, 0, 0, 0, 0, 16'h048D, 1);
        idle(5);
        beat(0, 16'h048D, 0, 0, 0, 0, 0, 16'hB646, 1);
        beat(0, 16'hB646, 0, 0, 1, 0, 0, 16'h5B23, 1);

        // resync with a mismatching locked beat still counts the error
        beat(0, 16'h0000, 0, 1, 0, 1, 1, 16'h0000, 0);
        // resync beats lock acquisition on the same beat
        beat(0, 16'h0001, 0, 0, 0, 0, 1, 16'hB400, 1);
        beat(0, 16'hB400, 0, 0, 0, 0, 1, 16'h5A00, 1);
        beat(0, 16'h5A00, 0, 0, 0, 0, 1, 16'h2D00, 1);
        beat(0, 16'h2D00, 0, 1, 0, 0, 1, 16'h0000, 0);
        beat(0, 16'h1680, 0, 0, 0, 0, 1, 16'h0B40, 1);
        beat(0, 16'h0B40, 0, 0, 0, 0, 1, 16'h05A0, 1);
        beat(0, 16'h05A0, 0, 0, 0, 0, 1, 16'h02D0, 1);
        beat(0, 16'h02D0, 0, 0, 1, 0, 1, 16'h0168, 1);
        // accumulate to 7 errors without losing lock
        beat(0, 16'hFFFF, 0, 0, 1, 1, 2, 16'h00B4, 1);
        beat(0, 16'hFFFF, 0, 0, 1, 1, 3, 16'h005A, 1);
        beat(0, 16'h005A, 0, 0, 1, 0, 3, 16'h002D, 1);
        beat(0, 16'hFFFF, 0, 0, 1, 1, 4, 16'hB416, 1);
        beat(0, 16'hFFFF, 0, 0, 1, 1, 5, 16'h5A0B, 1);
        beat(0, 16'h5A0B, 0, 0, 1, 0, 5, 16'h9905, 1);
        beat(0, 16'hFFFF, 0, 0, 1, 1, 6, 16'hF882, 1);
        beat(0, 16'hFFFF, 0, 0, 1, 1, 7, 16'h7C41, 1);

        // asynchronous reset mid-cycle while err_o is still high
        rst_n = 1'b0;
        #1;
        cmp("async_locked", -1, {31'd0, locked_a}, 32'd0);
        cmp("async_err", -1, {31'd0, err_a}, 32'd0);
        cmp("async_count", -1, {16'd0, cnt_a}, 32'd0);
        cmp("async_expected", -1, {16'd0, exp_a}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        beat(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1);
        beat(0, 16'h0001, 0, 0, 0, 0, 0, 16'hB400, 1);

        // saturation on the 4-bit counter instance, then clear with a same-beat error
        beat(1, 16'h0001, 0, 0, 0, 0, 0, 16'hB400, 1);
        beat(1, 16'hB400, 0, 0, 0, 0, 0, 16'h5A00, 1);
        beat(1, 16'h5A00, 0, 0, 0, 0, 0, 16'h2D00, 1);
        beat(1, 16'h2D00, 0, 0, 1, 0, 0, 16'h1680, 1);
        for (int i = 0; i < 20; i++)
            beat(1, 16'h0000, 0, 0, 1, 1, (i + 1 > 15) ? 16'd15 : 16'(i + 1), 16'h0000, 0);
        beat(1, 16'h0000, 1, 0, 1, 1, 1, 16'h0000, 0);

        idle(2);
        cmp("sb_drain", -1, sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
